if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined MIPS core. It holds the program counter, computes PC+4, and selects the next PC from sequential, branch and jump sources. It drives the instruction-memory address and captures instruction and PC+4 into the IF/ID pipeline register. It honours stall and flush requests from the hazard unit, and keeps saturating performance counters for redirects and stalls.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/pc_incr.sv | 15 +
 rtl/if_fetch_stage.sv | 92 +++++++++
 tb/tb_if_fetch_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and helpers for the MIPS core
//
// Contents:
//   INSTR_W          instruction / address word width
//   RESET_PC_DEFAULT default PC loaded on reset
//   NOP_WORD         bubble instruction (sll $0,$0,0)
//   PC_ALIGN_MASK    clears the two low address bits
//   align_pc()       aligns an address down to a word boundary
package cpu_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_incr.sv
// rtl/pc_incr.sv - combinational PC+4 adder
//
// Ports:
//   addr  in   32  current PC
//   sum   out  32  addr + 4, wraps modulo 2^32 with no carry out
module pc_incr
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] addr,
  output logic [INSTR_W-1:0] sum
);

  assign sum = addr + 32'd4;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS instruction-fetch stage with IF/ID register
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   stall, flush                  hazard-unit hold / bubble requests
//   branch_taken, branch_target   ID-stage branch redirect
//   jump, jump_target             ID-stage jump redirect
//   imem_addr, imem_rdata         instruction memory (combinational read)
//   pc                            program counter register
//   if_id_instr/pc4/valid         IF/ID pipeline register
//   redirect_cnt, stall_cnt       saturating performance counters
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_WORD,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0] pc4;
  logic [31:0] next_pc;
  logic        redirect;

  pc_incr u_pc_incr (
    .addr (pc),
    .sum  (pc4)
  );

  assign imem_addr = pc;
  assign redirect  = branch_taken | jump;

  // A redirect wins over stall: the instruction in ID that caused the
  // redirect is not the one being held by a load-use stall.
  always_comb begin
    next_pc = pc4;
    if (branch_taken)   next_pc = align_pc(branch_target);
    else if (jump)      next_pc = align_pc(jump_target);
    else if (stall)     next_pc = pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      if_id_instr  <= NOP_INSTR;
      if_id_pc4    <= 32'h0000_0000;
      if_id_valid  <= 1'b0;
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      pc <= next_pc;

      // The word fetched alongside a redirect is on the wrong path, so it is
      // squashed; if_id_pc4 is left alone since a bubble never uses it.
      if (flush || redirect) begin
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end else if (!stall) begin
        if_id_instr <= imem_rdata;
        if_id_pc4   <= pc4;
        if_id_valid <= 1'b1;
      end

      if (redirect && redirect_cnt != CNT_MAX)
        redirect_cnt <= redirect_cnt + CNT_ONE;

      // Only stalls that actually held the PC are counted.
      if (stall && !redirect && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        stall, flush, branch_taken, jump;
  logic [31:0] branch_target, jump_target;

  logic [31:0] imem_addr, imem_rdata, pc, if_id_instr, if_id_pc4;
  logic        if_id_valid;
  logic [15:0] redirect_cnt, stall_cnt;

  logic [31:0] s_imem_addr, s_imem_rdata, s_pc, s_instr, s_pc4;
  logic        s_valid;
  logic [2:0]  s_redirect_cnt, s_stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state: counts are kept unbounded and clipped at compare time.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_rc, m_sc;

  if_fetch_stage dut (
    .clk (clk), .rst (rst), .stall (stall), .flush (flush),
    .branch_taken (branch_taken), .branch_target (branch_target),
    .jump (jump), .jump_target (jump_target),
    .imem_addr (imem_addr), .imem_rdata (imem_rdata), .pc (pc),
    .if_id_instr (if_id_instr), .if_id_pc4 (if_id_pc4), .if_id_valid (if_id_valid),
    .redirect_cnt (redirect_cnt), .stall_cnt (stall_cnt)
  );

  if_fetch_stage #(.CNT_W(3)) dut_small (
    .clk (clk), .rst (rst), .stall (stall), .flush (flush),
    .branch_taken (branch_taken), .branch_target (branch_target),
    .jump (jump), .jump_target (jump_target),
    .imem_addr (s_imem_addr), .imem_rdata (s_imem_rdata), .pc (s_pc),
    .if_id_instr (s_instr), .if_id_pc4 (s_pc4), .if_id_valid (s_valid),
    .redirect_cnt (s_redirect_cnt), .stall_cnt (s_stall_cnt)
  );

  assign imem_rdata   = imem_addr ^ K;
  assign s_imem_rdata = s_imem_addr ^ K;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] sat16(input int n);
    return (n > 65535) ? 16'hFFFF : n[15:0];
  endfunction

  function automatic logic [2:0] sat3(input int n);
    return (n > 7) ? 3'd7 : n[2:0];
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_rc = 0; m_sc = 0;
  endtask

  // Advance the reference by one clock using the currently driven inputs.
  task automatic model_step();
    logic [31:0] tgt;
    logic        redir;
    redir = branch_taken | jump;
    tgt   = branch_taken ? branch_target : jump_target;
    tgt   = tgt - (tgt % 4);
    if (redir || flush) begin
      m_instr = 32'h0; m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = m_pc ^ K; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
    end
    if (redir) m_rc++;
    if (stall && !redir) m_sc++;
    if (redir)       m_pc = tgt;
    else if (!stall) m_pc = m_pc + 32'd4;
  endtask

  task automatic cycle(input logic s, input logic f, input logic b, input logic j,
                       input logic [31:0] bt, input logic [31:0] jt);
    stall = s; flush = f; branch_taken = b; jump = j;
    branch_target = bt; jump_target = jt;
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 0; flush = 0; branch_taken = 0; jump = 0;
    branch_target = 0; jump_target = 0;
    model_reset();
    #3;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0) begin
      errors++; $display("FAIL reset_ifid got v=%b i=%h p=%h exp 0", if_id_valid, if_id_instr, if_id_pc4); end
    checks++; if (redirect_cnt !== 16'h0 || stall_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_cnt got %h/%h exp 0", redirect_cnt, stall_cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr got %h exp 0", imem_addr); end
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 4; k++) begin
      cycle(0, 0, 0, 0, 0, 0);
      checks++; if (if_id_pc4 !== 32'(4 * k)) begin
        errors++; $display("FAIL seq_pc4 k=%0d got %h exp %h", k, if_id_pc4, 32'(4 * k)); end
      checks++; if (if_id_instr !== (32'(4 * (k - 1)) ^ K) || if_id_valid !== 1'b1) begin
        errors++; $display("FAIL seq_instr k=%0d got %h v=%b exp %h v=1", k, if_id_instr, if_id_valid, 32'(4 * (k - 1)) ^ K); end
    end
  endtask

  task automatic test_stall();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_start_pc got %h exp 10", pc); end
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 0, 0, 0, 0);
      checks++; if (pc !== 32'h10 || if_id_instr !== 32'hA5A5_000C || if_id_pc4 !== 32'h10) begin
        errors++; $display("FAIL stall_hold got pc=%h i=%h p=%h exp 10/a5a5000c/10", pc, if_id_instr, if_id_pc4); end
    end
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt got %0d exp 3", stall_cnt); end
    cycle(0, 0, 0, 0, 0, 0);
    checks++; if (pc !== 32'h14 || if_id_instr !== 32'hA5A5_0010 || if_id_pc4 !== 32'h14) begin
      errors++; $display("FAIL stall_resume got pc=%h i=%h p=%h exp 14/a5a50010/14", pc, if_id_instr, if_id_pc4); end
  endtask

  task automatic test_branch();
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL br_start_pc got %h exp 20", pc); end
    cycle(0, 0, 1, 0, 32'h0000_0102, 0);
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL br_pc got %h exp 100", pc); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h20) begin
      errors++; $display("FAIL br_bubble got v=%b i=%h p=%h exp 0/0/20", if_id_valid, if_id_instr, if_id_pc4); end
    checks++; if (redirect_cnt !== 16'd1) begin errors++; $display("FAIL br_rcnt got %0d exp 1", redirect_cnt); end
    cycle(0, 0, 0, 0, 0, 0);
    checks++; if (if_id_instr !== 32'hA5A5_0100 || if_id_valid !== 1'b1 || pc !== 32'h104) begin
      errors++; $display("FAIL br_target got i=%h v=%b pc=%h exp a5a50100/1/104", if_id_instr, if_id_valid, pc); end
  endtask

  task automatic test_priority();
    cycle(1, 0, 1, 1, 32'h200, 32'h400);
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL prio_pc got %h exp 200", pc); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
      errors++; $display("FAIL prio_bubble got v=%b i=%h exp 0/0", if_id_valid, if_id_instr); end
    checks++; if (stall_cnt !== 16'd3 || redirect_cnt !== 16'd2) begin
      errors++; $display("FAIL prio_cnt got s=%0d r=%0d exp 3/2", stall_cnt, redirect_cnt); end
  endtask

  task automatic test_wrap();
    cycle(0, 0, 0, 1, 0, 32'hFFFF_FFFF);
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_jump_pc got %h exp fffffffc", pc); end
    cycle(0, 0, 0, 0, 0, 0);
    checks++; if (pc !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_instr !== 32'h5A5A_FFFC) begin
      errors++; $display("FAIL wrap got pc=%h p=%h i=%h exp 0/0/5a5afffc", pc, if_id_pc4, if_id_instr); end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 300; n++) begin
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
            $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 1,
            $urandom, $urandom);
      checks++;
      if (pc !== m_pc || if_id_instr !== m_instr || if_id_pc4 !== m_pc4 || if_id_valid !== m_valid ||
          redirect_cnt !== sat16(m_rc) || stall_cnt !== sat16(m_sc) ||
          s_redirect_cnt !== sat3(m_rc) || s_stall_cnt !== sat3(m_sc)) begin
        errors++;
        if (bad++ < 5)
          $display("FAIL rand n=%0d got pc=%h i=%h p=%h v=%b r=%0d s=%0d exp pc=%h i=%h p=%h v=%b r=%0d s=%0d",
                   n, pc, if_id_instr, if_id_pc4, if_id_valid, redirect_cnt, stall_cnt,
                   m_pc, m_instr, m_pc4, m_valid, sat16(m_rc), sat16(m_sc));
      end
    end
  endtask

  task automatic test_saturation();
    repeat (10) cycle(1, 0, 0, 0, 0, 0);
    repeat (10) cycle(0, 0, 0, 1, 0, 32'h40);
    checks++; if (s_stall_cnt !== 3'd7 || s_redirect_cnt !== 3'd7) begin
      errors++; $display("FAIL sat_small got s=%0d r=%0d exp 7/7", s_stall_cnt, s_redirect_cnt); end
    checks++; if (stall_cnt !== sat16(m_sc) || redirect_cnt !== sat16(m_rc)) begin
      errors++; $display("FAIL sat_main got s=%0d r=%0d exp %0d/%0d", stall_cnt, redirect_cnt, sat16(m_sc), sat16(m_rc)); end
  endtask

  task automatic test_async_reset();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h300;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (pc !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0) begin
      errors++; $display("FAIL async_rst got pc=%h v=%b i=%h p=%h exp 0", pc, if_id_valid, if_id_instr, if_id_pc4); end
    checks++; if (stall_cnt !== 16'h0 || redirect_cnt !== 16'h0 || s_stall_cnt !== 3'd0 || s_redirect_cnt !== 3'd0) begin
      errors++; $display("FAIL async_rst_cnt got %0d/%0d/%0d/%0d exp 0", stall_cnt, redirect_cnt, s_stall_cnt, s_redirect_cnt); end
    stall = 1'b0; branch_taken = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cycle(0, 0, 0, 0, 0, 0);
    checks++; if (pc !== 32'h4 || if_id_instr !== K || if_id_valid !== 1'b1 || if_id_pc4 !== 32'h4) begin
      errors++; $display("FAIL post_rst got pc=%h i=%h v=%b p=%h exp 4/a5a50000/1/4", pc, if_id_instr, if_id_valid, if_id_pc4); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_priority();
    test_wrap();
    test_random();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
